// File: rtl/ofdm_sp_ram.sv
// ofdm_sp_ram: parametrised single-port synchronous block RAM for the OFDM
// datapath. It provides byte write enables, bypass or pipelined read output,
// three write modes and a sequencer that clears the whole array after reset
// or on request. The array is inferred so that it maps onto BSRAM.
module ofdm_sp_ram #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    READ_MODE      = 0,
    parameter int                    WRITE_MODE     = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    srst_i,
    input  logic                    clear_i,
    input  logic                    ce_i,
    input  logic                    oce_i,
    input  logic                    wre_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   ad_i,
    input  logic [DATA_WIDTH-1:0]   din_i,
    output logic [DATA_WIDTH-1:0]   dout_o,
    output logic                    dout_valid_o,
    output logic                    busy_o
);

    localparam int   NUM_BYTES = DATA_WIDTH / 8;
    localparam int   DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic WR_RESP   = (WRITE_MODE != 0);
    localparam logic WR_MERGE  = (WRITE_MODE == 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clrAddr_q, clrAddr_d;
    logic                    clearStart;
    logic                    accessEn;
    logic                    writeEn;
    logic                    respEn;
    logic                    flushOut;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   s1Data_q;
    logic [DATA_WIDTH-1:0]   s1Din_q;
    logic [NUM_BYTES-1:0]    s1Be_q;
    logic                    s1Merge_q;
    logic                    s1Valid_q;
    logic [DATA_WIDTH-1:0]   s1Word;

    // A clear request is only honoured from IDLE, and it beats any access
    // presented in the same cycle. Outputs are flushed while clearing.
    assign busy_o     = (state_q == ST_CLEAR);
    assign accessEn   = ce_i && (state_q == ST_IDLE) && !clear_i;
    assign writeEn    = accessEn && wre_i;
    assign respEn     = accessEn && (!wre_i || WR_RESP);
    assign flushOut   = srst_i || busy_o || clearStart;

    // Clear sequencer next state: walk every address once, then go idle.
    always_comb begin
        state_d    = state_q;
        clrAddr_d  = clrAddr_q;
        clearStart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d    = ST_CLEAR;
                    clrAddr_d  = '0;
                    clearStart = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clrAddr_q == '1) begin
                    state_d   = ST_IDLE;
                    clrAddr_d = '0;
                end else begin
                    clrAddr_d = clrAddr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clrAddr_d = '0;
            end
        endcase
    end

    // Sequencer state and clear address; reset restarts the clear when enabled.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    // Array write port: clear words have precedence, otherwise per-byte writes.
    always_ff @(posedge clk_i) begin
        if (busy_o) begin
            mem[clrAddr_q] <= CLEAR_VALUE;
        end else if (writeEn) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (be_i[b]) begin
                    mem[ad_i][8*b +: 8] <= din_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 1 captures the pre-write word plus the write data so that
    // write-through can be merged after the array read.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1Data_q  <= '0;
            s1Din_q   <= '0;
            s1Be_q    <= '0;
            s1Merge_q <= 1'b0;
            s1Valid_q <= 1'b0;
        end else if (flushOut) begin
            s1Data_q  <= '0;
            s1Din_q   <= '0;
            s1Be_q    <= '0;
            s1Merge_q <= 1'b0;
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= respEn;
            if (respEn) begin
                s1Data_q  <= mem[ad_i];
                s1Din_q   <= din_i;
                s1Be_q    <= be_i;
                s1Merge_q <= wre_i && WR_MERGE;
            end
        end
    end

    // Overlay the written bytes on the old word for write-through responses.
    always_comb begin
        s1Word = s1Data_q;
        if (s1Merge_q) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (s1Be_q[b]) begin
                    s1Word[8*b +: 8] = s1Din_q[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_MODE == 0) begin : gBypass
            logic unusedOce;

            assign unusedOce    = oce_i;
            assign dout_o       = s1Word;
            assign dout_valid_o = s1Valid_q;
        end else begin : gPipe
            logic [DATA_WIDTH-1:0] dout2_q;
            logic                  valid2_q;

            // Second output stage advances only when oce is high.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    dout2_q  <= '0;
                    valid2_q <= 1'b0;
                end else if (flushOut) begin
                    dout2_q  <= '0;
                    valid2_q <= 1'b0;
                end else begin
                    valid2_q <= oce_i && s1Valid_q;
                    if (oce_i && s1Valid_q) begin
                        dout2_q <= s1Word;
                    end
                end
            end

            assign dout_o       = dout2_q;
            assign dout_valid_o = valid2_q;
        end
    endgenerate

endmodule

// File: tb/tb_ofdm_sp_ram.sv
// tb_ofdm_sp_ram: drives six RAM instances covering every read/write mode
// combination with the same stimulus and scoreboards each against a
// word-level memory model.
module tb_ofdm_sp_ram;

    localparam int NDUT  = 6;
    localparam int DEPTH = 16;
    localparam logic [15:0] CV = 16'hA5A5;

    typedef struct {
        int          edgeIdx;
        int          dutIdx;
        logic        valid;
        logic [15:0] data;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        srst;
    logic        clear;
    logic        ce;
    logic        oce;
    logic        wre;
    logic [1:0]  be;
    logic [3:0]  ad;
    logic [15:0] din;

    logic [15:0] doutW  [NDUT];
    logic        validW [NDUT];
    logic        busyW  [NDUT];

    int          cyc;
    int          checks;
    int          errors;
    exp_t        expQ[$];

    logic [15:0] refMem [DEPTH];
    int          busyCnt;
    logic        pendV  [NDUT];
    logic [15:0] pendW  [NDUT];
    logic [15:0] expD   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        ofdm_sp_ram #(
            .DATA_WIDTH    (16),
            .ADDR_WIDTH    (4),
            .READ_MODE     (g % 2),
            .WRITE_MODE    (g / 2),
            .CLEAR_ON_RESET(1),
            .CLEAR_VALUE   (CV)
        ) dut (
            .clk_i       (clk),
            .reset_n_i   (reset_n),
            .srst_i      (srst),
            .clear_i     (clear),
            .ce_i        (ce),
            .oce_i       (oce),
            .wre_i       (wre),
            .be_i        (be),
            .ad_i        (ad),
            .din_i       (din),
            .dout_o      (doutW[g]),
            .dout_valid_o(validW[g]),
            .busy_o      (busyW[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, act, expv, cyc);
        end
    endtask

    // Compare every expected entry that belongs to the edge just taken.
    always @(negedge clk) begin
        if (reset_n) begin
            while (expQ.size() > 0 && expQ[0].edgeIdx <= cyc) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("dut%0d valid", e.dutIdx), {15'b0, validW[e.dutIdx]}, {15'b0, e.valid});
                checkOutput($sformatf("dut%0d dout", e.dutIdx), doutW[e.dutIdx], e.data);
                checkOutput($sformatf("dut%0d busy", e.dutIdx), {15'b0, busyW[e.dutIdx]}, {15'b0, e.busy});
            end
        end
    end

    task automatic modelReset();
        busyCnt = DEPTH;
        for (int i = 0; i < NDUT; i++) begin
            pendV[i] = 1'b0;
            pendW[i] = '0;
            expD[i]  = '0;
        end
    endtask

    // One clock of stimulus: drive inputs, advance the reference, queue expectations.
    task automatic applyStimulus(input logic ceV, input logic wreV, input logic [1:0] beV,
                                 input logic [3:0] adV, input logic [15:0] dinV,
                                 input logic clrV, input logic srstV, input logic oceV);
        logic [15:0] oldW;
        logic [15:0] newW;
        logic        expV [NDUT];
        logic        flush;
        exp_t        e;
        ce = ceV; wre = wreV; be = beV; ad = adV; din = dinV;
        clear = clrV; srst = srstV; oce = oceV;
        flush = 1'b0;
        oldW = '0;
        newW = '0;
        if (busyCnt > 0) begin
            refMem[DEPTH - busyCnt] = CV;
            busyCnt--;
            flush = 1'b1;
        end else if (clrV) begin
            busyCnt = DEPTH;
            flush = 1'b1;
        end else if (ceV) begin
            oldW = refMem[adV];
            newW = oldW;
            if (beV[0]) newW[7:0]  = dinV[7:0];
            if (beV[1]) newW[15:8] = dinV[15:8];
            if (wreV) refMem[adV] = newW;
        end
        for (int i = 0; i < NDUT; i++) begin
            logic        hasResp;
            logic [15:0] resp;
            int          wm;
            hasResp = 1'b0;
            resp    = '0;
            wm      = i / 2;
            expV[i] = 1'b0;
            if (!flush && ceV) begin
                if (!wreV) begin
                    hasResp = 1'b1; resp = oldW;
                end else if (wm == 1) begin
                    hasResp = 1'b1; resp = newW;
                end else if (wm == 2) begin
                    hasResp = 1'b1; resp = oldW;
                end
            end
            if (flush || srstV) begin
                pendV[i] = 1'b0;
                expD[i]  = '0;
            end else if (i % 2 == 0) begin
                if (hasResp) begin
                    expD[i] = resp;
                    expV[i] = 1'b1;
                end
            end else begin
                if (oceV && pendV[i]) begin
                    expD[i] = pendW[i];
                    expV[i] = 1'b1;
                end
                pendV[i] = hasResp;
                pendW[i] = resp;
            end
            e.edgeIdx = cyc + 1;
            e.dutIdx  = i;
            e.valid   = expV[i];
            e.data    = expD[i];
            e.busy    = (busyCnt > 0);
            expQ.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset pulse placed away from the clock edges.
    task automatic doReset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        ce = 1'b0; wre = 1'b0; clear = 1'b0; srst = 1'b0;
        expQ.delete();
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        cyc = 0; checks = 0; errors = 0;
        reset_n = 1'b0; srst = 1'b0; clear = 1'b0; ce = 1'b0; oce = 1'b0;
        wre = 1'b0; be = 2'b00; ad = '0; din = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Power-up clear, then read every address back.
        idleCycles(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 2'b00, 4'(a), 16'h0, 1'b0, 1'b0, 1'b1);

        // Basic write then read.
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd3, 16'h0, 1'b0, 1'b0, 1'b1);

        // Byte enables.
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd7, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b01, 4'd7, 16'h00AB, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd7, 16'h0, 1'b0, 1'b0, 1'b1);

        // Output enable on the pipelined instances.
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd3, 16'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd7, 16'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        // Write modes: old word, merged word, then read back.
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd5, 16'h1111, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd5, 16'h2222, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd5, 16'h0, 1'b0, 1'b0, 1'b1);
        idleCycles(2);

        // srst together with a read, and with a write.
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd5, 16'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd9, 16'h5A5A, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd9, 16'h0, 1'b0, 1'b0, 1'b1);
        idleCycles(2);

        // Clear pulse colliding with a write, then reset at clear cycle 5.
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd2, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        idleCycles(5);
        doReset();
        idleCycles(DEPTH + 1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd5, 16'h0, 1'b0, 1'b0, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
                          16'($urandom), ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) != 0));
        end

        idleCycles(4);
        @(negedge clk);
        #1;
        checkOutput("scoreboard drained", 16'(expQ.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
